// File: rtl/key_lookup_exact.sv
// key_lookup_exact: exact-match lookup stage behind the key extractor.
// A DEPTH-entry key table is compared in parallel against the incoming key.
// The PHV is returned two cycles later with a hit flag and the index of the
// lowest matching entry. Table entries are written in-band over the control
// AXI-Stream chain. Control packets addressed elsewhere are forwarded unchanged.
module key_lookup_exact #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int STAGE_ID             = 0,
    parameter int LOOKUP_ID            = 2,
    parameter int PHV_LEN              = 4*8*64+256,
    parameter int KEY_LEN              = 8*32+1,
    parameter int DEPTH                = 16,
    parameter int ADDR_W               = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [PHV_LEN-1:0]                phv_in,
    input  logic                              phv_valid_in,
    input  logic [KEY_LEN-1:0]                key_in,
    input  logic                              key_valid_in,
    output logic                              ready_out,
    output logic [PHV_LEN-1:0]                phv_out,
    output logic                              phv_valid_out,
    output logic [ADDR_W-1:0]                 match_addr,
    output logic                              match_hit,
    input  logic                              ready_in,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH/8;

    typedef enum logic [2:0] {IDLE_C, PARSE_C, WR_KEY_HI, WR_KEY_LO, FLUSH_C} ctrl_state_t;

    // Payload beats carry the key with byte 0 in the most significant lane.
    function automatic logic [DW-1:0] byte_swap(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < KW; i++) begin
            r[8*i +: 8] = d[8*(KW-1-i) +: 8];
        end
        return r;
    endfunction

    // ---------------- table storage ----------------
    logic [DEPTH-1:0]   entry_valid_r;
    logic [KEY_LEN-1:0] entry_key_r [DEPTH];
    logic               wr_en_r;
    logic [ADDR_W-1:0]  wr_addr_r;
    logic [KEY_LEN-1:0] wr_key_r;
    logic               wr_valid_r;

    // ---------------- datapath ----------------
    logic [DEPTH-1:0]   hit_s;
    logic [PHV_LEN-1:0] phv_s1_r;
    logic               valid_s1_r;
    logic [DEPTH-1:0]   hit_s1_r;
    logic [ADDR_W-1:0]  enc_addr_s;
    logic               enc_hit_s;

    assign ready_out = ready_in;

    // Parallel compare of the incoming key against every valid entry.
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_s[i] = key_valid_in && entry_valid_r[i] && (entry_key_r[i] == key_in);
        end
    end

    // Stage 1: capture PHV and hit vector while downstream is ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_s1_r   <= '0;
            valid_s1_r <= 1'b0;
            hit_s1_r   <= '0;
        end else if (ready_in) begin
            phv_s1_r   <= phv_in;
            valid_s1_r <= phv_valid_in;
            hit_s1_r   <= phv_valid_in ? hit_s : {DEPTH{1'b0}};
        end else begin
            phv_s1_r   <= phv_s1_r;
            valid_s1_r <= valid_s1_r;
            hit_s1_r   <= hit_s1_r;
        end
    end

    // Priority encoder: the lowest matching index wins.
    always_comb begin
        enc_addr_s = '0;
        enc_hit_s  = 1'b0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            enc_addr_s = hit_s1_r[i] ? ADDR_W'(i) : enc_addr_s;
            enc_hit_s  = enc_hit_s | hit_s1_r[i];
        end
    end

    // Stage 2: registered outputs toward the action stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_out       <= '0;
            phv_valid_out <= 1'b0;
            match_addr    <= '0;
            match_hit     <= 1'b0;
        end else if (ready_in) begin
            phv_out       <= phv_s1_r;
            phv_valid_out <= valid_s1_r;
            match_addr    <= enc_addr_s;
            match_hit     <= enc_hit_s;
        end else begin
            phv_out       <= phv_out;
            phv_valid_out <= phv_valid_out;
            match_addr    <= match_addr;
            match_hit     <= match_hit;
        end
    end

    // Commit a pending write to the entry valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_valid_r <= '0;
        end else if (wr_en_r) begin
            entry_valid_r[wr_addr_r] <= wr_valid_r;
        end else begin
            entry_valid_r <= entry_valid_r;
        end
    end

    // Commit a pending write to the key storage (contents gated by valid bits).
    always_ff @(posedge clk) begin
        if (wr_en_r) begin
            entry_key_r[wr_addr_r] <= wr_key_r;
        end
    end

    // ---------------- control path ----------------
    ctrl_state_t          state_r, state_nx;
    logic [DW-1:0]        hdr_data_r, pend_data_r;
    logic [UW-1:0]        hdr_user_r, pend_user_r;
    logic [KW-1:0]        hdr_keep_r, pend_keep_r;
    logic                 hdr_last_r, pend_last_r, pend_valid_r, drop_r;
    logic [KEY_LEN-2:0]   key_hi_r;
    logic [DW-1:0]        swapped_s;
    logic                 hdr_match_s;
    logic                 hdr_load_s, pend_load_s, idx_load_s, hi_load_s, wr_fire_s;
    logic                 pend_valid_nx, drop_nx, out_valid_nx, out_last_nx;
    logic [DW-1:0]        out_data_nx;
    logic [UW-1:0]        out_user_nx;
    logic [KW-1:0]        out_keep_nx;

    assign swapped_s   = byte_swap(c_s_axis_tdata);
    assign hdr_match_s = (hdr_data_r[115 +: 5] == 5'(STAGE_ID)) &&
                         (hdr_data_r[112 +: 3] == 3'(LOOKUP_ID)) &&
                         (hdr_data_r[64 +: 16] == 16'hf2f1) &&
                         (hdr_data_r[120 +: 4] == 4'h0);

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE_C;
        end else begin
            state_r <= state_nx;
        end
    end

    // Control next-state decode; every state waits for tvalid.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE_C:    state_nx = (c_s_axis_tvalid && !c_s_axis_tlast) ? PARSE_C : IDLE_C;
            PARSE_C:   state_nx = !c_s_axis_tvalid ? PARSE_C : (hdr_match_s ? WR_KEY_HI : FLUSH_C);
            WR_KEY_HI: state_nx = !c_s_axis_tvalid ? WR_KEY_HI : (c_s_axis_tlast ? IDLE_C : WR_KEY_LO);
            WR_KEY_LO: state_nx = !c_s_axis_tvalid ? WR_KEY_LO : (c_s_axis_tlast ? IDLE_C : FLUSH_C);
            FLUSH_C: begin
                if (drop_r) begin
                    state_nx = (c_s_axis_tvalid && c_s_axis_tlast) ? IDLE_C : FLUSH_C;
                end else if (pend_valid_r && pend_last_r) begin
                    // Packet ends now; a beat arriving alongside starts the next one.
                    state_nx = !c_s_axis_tvalid ? IDLE_C : (c_s_axis_tlast ? FLUSH_C : PARSE_C);
                end else begin
                    state_nx = FLUSH_C;
                end
            end
            default:   state_nx = IDLE_C;
        endcase
    end

    // Control output decode: forwarding beats, header capture and write strobes.
    always_comb begin
        out_valid_nx  = 1'b0;
        out_data_nx   = c_m_axis_tdata;
        out_user_nx   = c_m_axis_tuser;
        out_keep_nx   = c_m_axis_tkeep;
        out_last_nx   = c_m_axis_tlast;
        pend_valid_nx = pend_valid_r;
        drop_nx       = drop_r;
        hdr_load_s    = 1'b0;
        pend_load_s   = 1'b0;
        idx_load_s    = 1'b0;
        hi_load_s     = 1'b0;
        wr_fire_s     = 1'b0;
        case (state_r)
            IDLE_C: begin
                if (c_s_axis_tvalid && c_s_axis_tlast) begin
                    // Single-beat packet carries no table write: forward it.
                    out_valid_nx = 1'b1;
                    out_data_nx  = c_s_axis_tdata;
                    out_user_nx  = c_s_axis_tuser;
                    out_keep_nx  = c_s_axis_tkeep;
                    out_last_nx  = 1'b1;
                end else begin
                    hdr_load_s = c_s_axis_tvalid;
                end
            end
            PARSE_C: begin
                if (c_s_axis_tvalid && hdr_match_s) begin
                    idx_load_s = 1'b1;
                end else if (c_s_axis_tvalid) begin
                    out_valid_nx  = 1'b1;
                    out_data_nx   = hdr_data_r;
                    out_user_nx   = hdr_user_r;
                    out_keep_nx   = hdr_keep_r;
                    out_last_nx   = hdr_last_r;
                    pend_load_s   = 1'b1;
                    pend_valid_nx = 1'b1;
                    drop_nx       = 1'b0;
                end else begin
                    out_valid_nx = 1'b0;
                end
            end
            WR_KEY_HI: hi_load_s = c_s_axis_tvalid;
            WR_KEY_LO: begin
                wr_fire_s = c_s_axis_tvalid;
                drop_nx   = (c_s_axis_tvalid && !c_s_axis_tlast) ? 1'b1 : drop_r;
            end
            FLUSH_C: begin
                if (drop_r) begin
                    drop_nx = !(c_s_axis_tvalid && c_s_axis_tlast);
                end else if (pend_valid_r && pend_last_r && c_s_axis_tvalid && !c_s_axis_tlast) begin
                    out_valid_nx  = 1'b1;
                    out_data_nx   = pend_data_r;
                    out_user_nx   = pend_user_r;
                    out_keep_nx   = pend_keep_r;
                    out_last_nx   = 1'b1;
                    pend_valid_nx = 1'b0;
                    hdr_load_s    = 1'b1;
                end else begin
                    out_valid_nx  = pend_valid_r;
                    out_data_nx   = pend_data_r;
                    out_user_nx   = pend_user_r;
                    out_keep_nx   = pend_keep_r;
                    out_last_nx   = pend_last_r;
                    pend_load_s   = c_s_axis_tvalid;
                    pend_valid_nx = c_s_axis_tvalid;
                end
            end
            default: out_valid_nx = 1'b0;
        endcase
    end

    // Control datapath registers: header, one-beat forward buffer, key staging, write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_data_r      <= '0;
            hdr_user_r      <= '0;
            hdr_keep_r      <= '0;
            hdr_last_r      <= 1'b0;
            pend_data_r     <= '0;
            pend_user_r     <= '0;
            pend_keep_r     <= '0;
            pend_last_r     <= 1'b0;
            pend_valid_r    <= 1'b0;
            drop_r          <= 1'b0;
            key_hi_r        <= '0;
            wr_en_r         <= 1'b0;
            wr_addr_r       <= '0;
            wr_key_r        <= '0;
            wr_valid_r      <= 1'b0;
            c_m_axis_tdata  <= '0;
            c_m_axis_tuser  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
        end else begin
            if (hdr_load_s) begin
                hdr_data_r <= c_s_axis_tdata;
                hdr_user_r <= c_s_axis_tuser;
                hdr_keep_r <= c_s_axis_tkeep;
                hdr_last_r <= c_s_axis_tlast;
            end
            if (pend_load_s) begin
                pend_data_r <= c_s_axis_tdata;
                pend_user_r <= c_s_axis_tuser;
                pend_keep_r <= c_s_axis_tkeep;
                pend_last_r <= c_s_axis_tlast;
            end
            if (idx_load_s) begin
                wr_addr_r <= hdr_data_r[128 +: ADDR_W];
            end
            if (hi_load_s) begin
                key_hi_r <= swapped_s;
            end
            if (wr_fire_s) begin
                wr_key_r   <= {key_hi_r, swapped_s[DW-1]};
                wr_valid_r <= swapped_s[DW-2];
            end
            pend_valid_r    <= pend_valid_nx;
            drop_r          <= drop_nx;
            wr_en_r         <= wr_fire_s;
            c_m_axis_tdata  <= out_data_nx;
            c_m_axis_tuser  <= out_user_nx;
            c_m_axis_tkeep  <= out_keep_nx;
            c_m_axis_tvalid <= out_valid_nx;
            c_m_axis_tlast  <= out_last_nx;
        end
    end
endmodule

// File: tb/tb_key_lookup_exact.sv
// Directed bench for key_lookup_exact with hand-derived expected values.
module tb_key_lookup_exact;
    localparam int PHV_LEN = 4*8*64+256;
    localparam int KEY_LEN = 8*32+1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [PHV_LEN-1:0]   phv_in, phv_out;
    logic                 phv_valid_in, key_valid_in, ready_out, phv_valid_out;
    logic [KEY_LEN-1:0]   key_in;
    logic [3:0]           match_addr;
    logic                 match_hit, ready_in;
    logic [255:0]         c_s_axis_tdata, c_m_axis_tdata;
    logic [127:0]         c_s_axis_tuser, c_m_axis_tuser;
    logic [31:0]          c_s_axis_tkeep, c_m_axis_tkeep;
    logic                 c_s_axis_tvalid, c_s_axis_tlast, c_m_axis_tvalid, c_m_axis_tlast;

    int n_checks = 0;
    int n_pass   = 0;

    logic [255:0] mon_data [$];
    logic [127:0] mon_user [$];
    logic         mon_last [$];

    logic [KEY_LEN-1:0] key_a, key_b, key_c, key_d;
    logic [PHV_LEN-1:0] phv_a, phv_b, phv_c, phv_d;

    key_lookup_exact dut (
        .clk(clk), .rst_n(rst_n),
        .phv_in(phv_in), .phv_valid_in(phv_valid_in),
        .key_in(key_in), .key_valid_in(key_valid_in),
        .ready_out(ready_out),
        .phv_out(phv_out), .phv_valid_out(phv_valid_out),
        .match_addr(match_addr), .match_hit(match_hit),
        .ready_in(ready_in),
        .c_s_axis_tdata(c_s_axis_tdata), .c_s_axis_tuser(c_s_axis_tuser),
        .c_s_axis_tkeep(c_s_axis_tkeep), .c_s_axis_tvalid(c_s_axis_tvalid),
        .c_s_axis_tlast(c_s_axis_tlast),
        .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tuser(c_m_axis_tuser),
        .c_m_axis_tkeep(c_m_axis_tkeep), .c_m_axis_tvalid(c_m_axis_tvalid),
        .c_m_axis_tlast(c_m_axis_tlast)
    );

    always #5 clk = ~clk;

    // Record every beat leaving on the control master port.
    always @(negedge clk) begin
        if (rst_n && c_m_axis_tvalid) begin
            mon_data.push_back(c_m_axis_tdata);
            mon_user.push_back(c_m_axis_tuser);
            mon_last.push_back(c_m_axis_tlast);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PHV_LEN-1:0] mk_phv(input logic [31:0] seed);
        logic [PHV_LEN-1:0] p;
        for (int i = 0; i < PHV_LEN/32; i++) p[32*i +: 32] = seed ^ (32'(i) * 32'h9e3779b9);
        return p;
    endfunction

    function automatic logic [255:0] byterev(input logic [255:0] d);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = d[8*(31-i) +: 8];
        return r;
    endfunction

    function automatic logic [255:0] hdr_beat(input logic [7:0] mod_id, input logic [15:0] flag,
                                               input logic [7:0] index);
        logic [255:0] d;
        d = 256'h0;
        d[112 +: 8] = mod_id;
        d[64 +: 16] = flag;
        d[128 +: 8] = index;
        return d;
    endfunction

    task automatic send_beat(input logic [255:0] d, input logic [127:0] u, input logic last);
        @(negedge clk);
        c_s_axis_tdata  = d;
        c_s_axis_tuser  = u;
        c_s_axis_tkeep  = 32'hffff_ffff;
        c_s_axis_tvalid = 1'b1;
        c_s_axis_tlast  = last;
    endtask

    task automatic ctrl_idle();
        @(negedge clk);
        c_s_axis_tvalid = 1'b0;
        c_s_axis_tlast  = 1'b0;
    endtask

    // Four-beat table write: header, filler, key[256:1], {key[0], valid}.
    task automatic write_pkt(input logic [7:0] index, input logic [KEY_LEN-1:0] key, input logic vld);
        logic [255:0] lo;
        lo    = 256'h0;
        lo[7] = key[0];
        lo[6] = vld;
        send_beat(hdr_beat(8'h02, 16'hf2f1, index), 128'h1, 1'b0);
        send_beat({8{32'h5a5a_0f0f}}, 128'h2, 1'b0);
        send_beat(byterev(key[KEY_LEN-1:1]), 128'h3, 1'b0);
        send_beat(lo, 128'h4, 1'b1);
    endtask

    task automatic write_entry(input logic [7:0] index, input logic [KEY_LEN-1:0] key, input logic vld);
        write_pkt(index, key, vld);
        ctrl_idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic lookup(input string tag, input logic [PHV_LEN-1:0] phv, input logic [KEY_LEN-1:0] key,
                          input logic kv, input logic exp_hit, input logic [3:0] exp_addr);
        @(negedge clk);
        phv_in = phv; key_in = key; phv_valid_in = 1'b1; key_valid_in = kv;
        @(negedge clk);
        phv_valid_in = 1'b0; key_valid_in = 1'b0;
        check({tag, "_lat"}, 64'(phv_valid_out), 64'd0);
        @(negedge clk);
        check({tag, "_vld"}, 64'(phv_valid_out), 64'd1);
        check({tag, "_hit"}, 64'(match_hit), 64'(exp_hit));
        check({tag, "_addr"}, 64'(match_addr), 64'(exp_addr));
        check({tag, "_phv"}, 64'(phv_out == phv), 64'd1);
    endtask

    // Three-beat packet for a different lookup id must come out untouched.
    task automatic fwd_test(input string tag);
        logic [255:0] d [3];
        logic [127:0] u [3];
        d[0] = hdr_beat(8'h01, 16'hf2f1, 8'd4);
        d[1] = {8{32'h1122_3344}};
        d[2] = {8{32'hcafe_f00d}};
        for (int i = 0; i < 3; i++) u[i] = 128'(i + 7);
        mon_data.delete(); mon_user.delete(); mon_last.delete();
        for (int i = 0; i < 3; i++) send_beat(d[i], u[i], (i == 2));
        ctrl_idle();
        repeat (5) @(negedge clk);
        check({tag, "_n"}, 64'(mon_data.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < mon_data.size()) begin
                check($sformatf("%s_d%0d", tag, i), 64'(mon_data[i] == d[i]), 64'd1);
                check($sformatf("%s_u%0d", tag, i), 64'(mon_user[i]), 64'(u[i]));
                check($sformatf("%s_l%0d", tag, i), 64'(mon_last[i]), 64'(i == 2));
            end
        end
    endtask

    initial begin
        key_a = {1'b1, {8{32'hdead_beef}}};
        key_b = {1'b0, {4{64'h0123_4567_89ab_cdef}}};
        key_c = {1'b1, {8{32'h1357_2468}}};
        key_d = {1'b0, {8{32'h0bad_f00d}}};
        phv_a = mk_phv(32'h1111_0001);
        phv_b = mk_phv(32'h2222_0002);
        phv_c = mk_phv(32'h3333_0003);
        phv_d = mk_phv(32'h4444_0004);

        rst_n = 1'b0; ready_in = 1'b0;
        phv_in = '0; key_in = '0; phv_valid_in = 1'b0; key_valid_in = 1'b0;
        c_s_axis_tdata = '0; c_s_axis_tuser = '0; c_s_axis_tkeep = '0;
        c_s_axis_tvalid = 1'b0; c_s_axis_tlast = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_vld", 64'(phv_valid_out), 64'd0);
        check("rst_hit", 64'(match_hit), 64'd0);
        check("rst_addr", 64'(match_addr), 64'd0);
        check("rst_phv", 64'(phv_out == '0), 64'd1);
        check("rst_cm", 64'(c_m_axis_tvalid), 64'd0);
        check("rst_rdy", 64'(ready_out), 64'd0);
        rst_n = 1'b1; ready_in = 1'b1;

        lookup("empty", phv_a, '0, 1'b1, 1'b0, 4'd0);

        mon_data.delete(); mon_user.delete(); mon_last.delete();
        write_entry(8'd3, key_a, 1'b1);
        lookup("e3", phv_b, key_a, 1'b1, 1'b1, 4'd3);
        check("consumed", 64'(mon_data.size()), 64'd0);

        write_entry(8'd5, key_b, 1'b1);
        write_entry(8'd2, key_b, 1'b1);
        lookup("prio", phv_c, key_b, 1'b1, 1'b1, 4'd2);
        write_entry(8'd2, key_b, 1'b0);
        lookup("inval", phv_d, key_b, 1'b1, 1'b1, 4'd5);

        fwd_test("fwd");
        lookup("after_fwd", phv_a, key_b, 1'b1, 1'b1, 4'd5);

        // Key sampled on the commit edge sees the old table, the next one the new.
        write_pkt(8'd7, key_c, 1'b1);
        @(negedge clk);
        c_s_axis_tvalid = 1'b0; c_s_axis_tlast = 1'b0;
        phv_in = phv_c; key_in = key_c; phv_valid_in = 1'b1; key_valid_in = 1'b1;
        @(negedge clk);
        phv_in = phv_d;
        @(negedge clk);
        phv_valid_in = 1'b0; key_valid_in = 1'b0;
        check("commit_old_vld", 64'(phv_valid_out), 64'd1);
        check("commit_old_hit", 64'(match_hit), 64'd0);
        check("commit_old_phv", 64'(phv_out == phv_c), 64'd1);
        @(negedge clk);
        check("commit_new_hit", 64'(match_hit), 64'd1);
        check("commit_new_addr", 64'(match_addr), 64'd7);
        check("commit_new_phv", 64'(phv_out == phv_d), 64'd1);
        repeat (2) @(negedge clk);

        write_entry(8'h1b, key_d, 1'b1);
        lookup("wrap", phv_b, key_d, 1'b1, 1'b1, 4'd11);
        lookup("nokey", phv_c, key_a, 1'b0, 1'b0, 4'd0);

        // Stall with a PHV sitting in the output stage.
        @(negedge clk);
        phv_in = phv_a; key_in = key_a; phv_valid_in = 1'b1; key_valid_in = 1'b1;
        @(negedge clk);
        phv_valid_in = 1'b0; key_valid_in = 1'b0;
        @(negedge clk);
        ready_in = 1'b0;
        phv_in = phv_b; key_in = key_b; phv_valid_in = 1'b1; key_valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_vld", i), 64'(phv_valid_out), 64'd1);
            check($sformatf("stall%0d_addr", i), 64'(match_addr), 64'd3);
            check($sformatf("stall%0d_hit", i), 64'(match_hit), 64'd1);
            check($sformatf("stall%0d_phv", i), 64'(phv_out == phv_a), 64'd1);
            check($sformatf("stall%0d_rdy", i), 64'(ready_out), 64'd0);
        end
        phv_valid_in = 1'b0; key_valid_in = 1'b0; ready_in = 1'b1;
        @(negedge clk);
        check("unstall_once", 64'(phv_valid_out), 64'd0);
        @(negedge clk);
        check("unstall_nosample", 64'(phv_valid_out), 64'd0);

        // Hold a valid hit at the outputs, start a write, then reset mid-cycle.
        @(negedge clk);
        phv_in = phv_c; key_in = key_a; phv_valid_in = 1'b1; key_valid_in = 1'b1;
        @(negedge clk);
        phv_valid_in = 1'b0; key_valid_in = 1'b0;
        @(negedge clk);
        ready_in = 1'b0;
        check("pre_rst_vld", 64'(phv_valid_out), 64'd1);
        send_beat(hdr_beat(8'h02, 16'hf2f1, 8'd9), 128'h1, 1'b0);
        send_beat({8{32'h0f0f_5a5a}}, 128'h2, 1'b0);
        ctrl_idle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_vld", 64'(phv_valid_out), 64'd0);
        check("arst_hit", 64'(match_hit), 64'd0);
        check("arst_addr", 64'(match_addr), 64'd0);
        check("arst_phv", 64'(phv_out == '0), 64'd1);
        check("arst_cm", 64'(c_m_axis_tvalid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; ready_in = 1'b1;

        lookup("post_a", phv_a, key_a, 1'b1, 1'b0, 4'd0);
        lookup("post_b", phv_b, key_b, 1'b1, 1'b0, 4'd0);
        fwd_test("post_fwd");
        write_entry(8'd1, key_a, 1'b1);
        lookup("post_wr", phv_d, key_a, 1'b1, 1'b1, 4'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/key_lookup_exact.md
Name: key_lookup_exact

Overview:
- Exact-match lookup stage directly downstream of the key extractor.
- Consumes the masked key and PHV, compares the key in parallel against a small software-written table, and emits the PHV with a hit flag and the matching entry index for the action stage.
- Table entries are written in-band over the control AXI-Stream daisy chain; all other control packets pass through unchanged.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, control stream data width (only 256 supported)
- C_S_AXIS_TUSER_WIDTH, 128, control stream tuser width
- STAGE_ID, 0, matched against mod_id[7:3]
- LOOKUP_ID, 2, matched against mod_id[2:0]
- PHV_LEN, 4*8*64+256, PHV width
- KEY_LEN, 8*32+1, key width (256 data bits + 1 comparison-result bit)
- DEPTH, 16, table entries (power of 2, ≤256)
- ADDR_W, 4, log2(DEPTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- phv_in  in  PHV_LEN  PHV from key extractor
- phv_valid_in  in  1  PHV valid
- key_in  in  KEY_LEN  masked key
- key_valid_in  in  1  key valid (arrives with phv_valid_in)
- ready_out  out  1  upstream may present data
- phv_out  out  PHV_LEN  delayed PHV
- phv_valid_out  out  1  output valid
- match_addr  out  ADDR_W  lowest matching entry index
- match_hit  out  1  any entry matched
- ready_in  in  1  downstream ready
- c_s_axis_tdata/tuser/tkeep/tvalid/tlast  in  256/128/32/1/1  control stream in
- c_m_axis_tdata/tuser/tkeep/tvalid/tlast  out  256/128/32/1/1  control stream out

Behaviour:
- Reset (async, rst_n=0): all outputs 0, all table valid bits 0, control FSM to IDLE_C, pipeline valids 0.
- Datapath is a 2-stage pipeline; stages advance only when ready_in=1. ready_out=ready_in.
  - S1 registers the PHV and a DEPTH-bit vector hit[i] = entry_valid[i] && (entry_key[i]==key_in).
  - S2 priority-encodes hit; lowest index wins.
- Latency: phv_valid_out asserts 2 cycles after phv_valid_in with ready_in held high.
- When ready_in=0: all pipeline registers and outputs hold; input is not sampled.
- phv_valid_in=1 with key_valid_in=0: treated as a miss (match_hit=0, match_addr=0).
- On a miss: match_addr=0, match_hit=0.
- Control header fields, all in beat 1: mod_id=tdata[112+:8], resv=tdata[120+:4], control_flag=tdata[64+:16], index=tdata[128+:8]. Payload beats use byte-reversed tdata ("swapped").
- Control FSM states:
  - IDLE_C: on tvalid, store beat 1; go to PARSE_C.
  - PARSE_C: on tvalid, if mod_id[7:3]==STAGE_ID, mod_id[2:0]==LOOKUP_ID, control_flag==16'hf2f1 and resv==0, latch index[ADDR_W-1:0] and go to WR_KEY_HI. Otherwise emit the stored beat 1 and go to FLUSH_C.
  - WR_KEY_HI: on tvalid, staging key[KEY_LEN-1:1] = swapped[255:0]; go to WR_KEY_LO.
  - WR_KEY_LO: on tvalid, staging key[0] = swapped[255]; valid bit = swapped[254]; pulse write; go to FLUSH_C.
  - FLUSH_C: forward input beats delayed 1 cycle; return to IDLE_C after forwarding a valid beat with tlast=1.
- Beats of a consumed (matching) packet are never forwarded.
- Table write commits on the clock edge after the write pulse. A key sampled into S1 on that commit edge or earlier sees the old entry; later keys see the new entry. Datapath is never stalled by control writes.
- Index ≥ DEPTH: upper bits are ignored, so the write wraps to index mod DEPTH.
- Writing an entry with valid=0 invalidates it.
- No control backpressure: tvalid gaps are tolerated in every state; a state waits until tvalid=1.

Test Plan:
- Reset, no writes; send key 0 with phv_valid_in -> 2 cycles later phv_valid_out=1, match_hit=0, match_addr=0, phv_out equals phv_in.
- Write entry 3 = key K (valid=1); send K -> match_hit=1, match_addr=3; control packet not seen on c_m_axis.
- Write K to entries 5 and 2; send K -> match_addr=2. Then invalidate entry 2 and send K -> match_addr=5.
- Control packet with mod_id[2:0]=1 (not LOOKUP_ID), 3 beats -> same 3 beats appear on c_m_axis unchanged, 1-cycle delay after beat 1; table unchanged.
- Hold ready_in=0 for 4 cycles with a PHV in S2 -> phv_out, match_hit and match_addr stable; ready_out=0; the PHV emitted once when ready_in returns to 1.
- Assert rst_n=0 asynchronously mid control write (in WR_KEY_HI) -> outputs 0 immediately; after release, all lookups miss and the next control packet parses from IDLE_C.
